// File: rtl/deck_pkg.sv
// -----------------------------------------------------------------------------
// deck_pkg
//
// Shared definitions for the deck-memory blocks (shuffler, dealer, hand
// scorer): deck geometry, card rank codes and the dealer state encoding.
// -----------------------------------------------------------------------------
package deck_pkg;

    // Deck geometry and memory-port widths.
    localparam int unsigned DECK_SIZE = 52;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned DATA_W    = 4;
    localparam int unsigned POINTS_W  = 4;

    // Rank codes. Anything outside RANK_ACE..RANK_KING is a corrupt card.
    localparam logic [DATA_W-1:0] RANK_ACE  = DATA_W'(1);
    localparam logic [DATA_W-1:0] RANK_TEN  = DATA_W'(10);
    localparam logic [DATA_W-1:0] RANK_KING = DATA_W'(13);

    // Face cards score the same as a ten.
    localparam logic [POINTS_W-1:0] FACE_POINTS = POINTS_W'(10);

    // Address of the final card; acknowledging it empties the deck.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DECK_SIZE - 1);
    localparam logic [ADDR_W-1:0] FULL_DECK = ADDR_W'(DECK_SIZE);

    // card_dealer states. Each state names the action performed on the clock
    // edge taken while in that state.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET_ADDR = 3'd1,
        ST_MEM_CLK  = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_PRESENT  = 3'd4,
        ST_EMPTY    = 3'd5
    } dealer_state_e;

endpackage

// File: rtl/card_points.sv
// -----------------------------------------------------------------------------
// card_points
//
// Combinational blackjack decoder for one card rank.
//   i_Rank     rank code, 1 = Ace .. 13 = King
//   o_Points   1..10 for a legal rank, 0 for a corrupt one
//   o_IsAce    rank is an Ace (scored as 1 here; the hand scorer
//              decides whether to promote it to 11)
//   o_CardErr  rank is 0, 14 or 15
// -----------------------------------------------------------------------------
module card_points
    import deck_pkg::*;
(
    input  logic [DATA_W-1:0]   i_Rank,
    output logic [POINTS_W-1:0] o_Points,
    output logic                o_IsAce,
    output logic                o_CardErr
);

    always_comb begin
        // NOTE: every output gets a default before any branch so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        o_Points  = '0;
        o_IsAce   = 1'b0;
        o_CardErr = 1'b0;

        if ((i_Rank == '0) || (i_Rank > RANK_KING)) begin
            o_CardErr = 1'b1;
        end else if (i_Rank > RANK_TEN) begin
            o_Points = FACE_POINTS;
        end else begin
            o_Points = POINTS_W'(i_Rank);
        end

        o_IsAce = (i_Rank == RANK_ACE);
    end

endmodule

// File: rtl/card_dealer.sv
// -----------------------------------------------------------------------------
// card_dealer
//
// Read-side counterpart of the shuffler. Once the deck is shuffled, fetches
// cards sequentially from the 52-entry deck memory and presents them one at a
// time to the game controller over a request / valid / acknowledge handshake.
//
// Ports
//   clk            system clock, rising edge
//   i_Reset_n      asynchronous active-low reset
//   i_Shuffled     deck ready; low holds the block idle and rewinds the deck
//   i_DealReq      deal request, sampled only in IDLE
//   i_CardAck      card taken, sampled only while a card is presented
//   i_MemData      deck memory read data
//   o_Address      deck memory address
//   o_MemClk       single-cycle memory clock pulse
//   o_Write        memory write enable, tied low
//   o_Card         rank of the presented card
//   o_Points       blackjack points of the presented card
//   o_IsAce        presented card is an Ace
//   o_CardErr      presented rank is illegal (0, 14, 15)
//   o_CardValid    card outputs are valid
//   o_Busy         fetch in progress
//   o_DeckEmpty    every card has been dealt
//   o_CardsLeft    cards remaining in the deck
//
// Fetch timeline for a request sampled at edge k:
//   k    IDLE      accept request
//   k+1  SET_ADDR  drive address, raise busy
//   k+2  MEM_CLK   raise memory clock (address already stable one cycle)
//   k+3  CAPTURE   drop memory clock, register and decode read data
//   k+4  PRESENT   raise valid; acks are honoured from the next edge on
// -----------------------------------------------------------------------------
module card_dealer
    import deck_pkg::*;
(
    input  logic                clk,
    input  logic                i_Reset_n,
    input  logic                i_Shuffled,
    input  logic                i_DealReq,
    input  logic                i_CardAck,
    input  logic [DATA_W-1:0]   i_MemData,
    output logic [ADDR_W-1:0]   o_Address,
    output logic                o_MemClk,
    output logic                o_Write,
    output logic [DATA_W-1:0]   o_Card,
    output logic [POINTS_W-1:0] o_Points,
    output logic                o_IsAce,
    output logic                o_CardErr,
    output logic                o_CardValid,
    output logic                o_Busy,
    output logic                o_DeckEmpty,
    output logic [ADDR_W-1:0]   o_CardsLeft
);

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    dealer_state_e         state_q;
    logic [ADDR_W-1:0]     ptr_q;        // next deck address to read, 0..DECK_SIZE
    logic [ADDR_W-1:0]     addr_q;
    logic                  mem_clk_q;
    logic [DATA_W-1:0]     card_q;
    logic [POINTS_W-1:0]   points_q;
    logic                  is_ace_q;
    logic                  card_err_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  empty_q;
    logic [ADDR_W-1:0]     left_q;

    // Decoded view of the memory read data, registered in CAPTURE.
    logic [POINTS_W-1:0]   dec_points;
    logic                  dec_is_ace;
    logic                  dec_card_err;

    card_points u_card_points (
        .i_Rank    (i_MemData),
        .o_Points  (dec_points),
        .o_IsAce   (dec_is_ace),
        .o_CardErr (dec_card_err)
    );

    // -------------------------------------------------------------------------
    // Dealer state machine
    // -------------------------------------------------------------------------
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, regardless of the
    // order the statements appear in.
    always_ff @(posedge clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            addr_q     <= '0;
            mem_clk_q  <= 1'b0;
            card_q     <= '0;
            points_q   <= '0;
            is_ace_q   <= 1'b0;
            card_err_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            empty_q    <= 1'b0;
            left_q     <= FULL_DECK;
        end else if (!i_Shuffled) begin
            // Deck not (or no longer) ready: abandon any fetch and rewind so
            // the next shuffle starts dealing from address 0.
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            addr_q     <= '0;
            mem_clk_q  <= 1'b0;
            card_q     <= '0;
            points_q   <= '0;
            is_ace_q   <= 1'b0;
            card_err_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            empty_q    <= 1'b0;
            left_q     <= FULL_DECK;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_DealReq && !empty_q) begin
                        state_q <= ST_SET_ADDR;
                    end
                end

                ST_SET_ADDR: begin
                    addr_q  <= ptr_q;
                    busy_q  <= 1'b1;
                    state_q <= ST_MEM_CLK;
                end

                ST_MEM_CLK: begin
                    mem_clk_q <= 1'b1;
                    state_q   <= ST_CAPTURE;
                end

                ST_CAPTURE: begin
                    mem_clk_q  <= 1'b0;
                    card_q     <= i_MemData;
                    points_q   <= dec_points;
                    is_ace_q   <= dec_is_ace;
                    card_err_q <= dec_card_err;
                    state_q    <= ST_PRESENT;
                end

                ST_PRESENT: begin
                    // The first PRESENT edge only raises valid; an ack can
                    // only refer to a card the consumer has already seen.
                    // A request arriving with the ack is deliberately dropped.
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (i_CardAck) begin
                        valid_q <= 1'b0;
                        ptr_q   <= ptr_q + 1'b1;
                        left_q  <= left_q - 1'b1;
                        if (ptr_q == LAST_ADDR) begin
                            // Pointer parks at DECK_SIZE; it never wraps.
                            empty_q <= 1'b1;
                            state_q <= ST_EMPTY;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end

                ST_EMPTY: begin
                    // Only a drop of i_Shuffled (or reset) leaves this state.
                    empty_q <= 1'b1;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output drive
    // -------------------------------------------------------------------------
    assign o_Address   = addr_q;
    assign o_MemClk    = mem_clk_q;
    assign o_Write     = 1'b0;
    assign o_Card      = card_q;
    assign o_Points    = points_q;
    assign o_IsAce     = is_ace_q;
    assign o_CardErr   = card_err_q;
    assign o_CardValid = valid_q;
    assign o_Busy      = busy_q;
    assign o_DeckEmpty = empty_q;
    assign o_CardsLeft = left_q;

endmodule

// File: tb/tb_card_dealer.sv
// -----------------------------------------------------------------------------
// tb_card_dealer
//
// Self-checking bench for card_dealer. A behavioural deck memory answers each
// o_MemClk pulse; expected cards are queued when a deal is requested and
// compared when the dealer presents a card.
// -----------------------------------------------------------------------------
module tb_card_dealer;

    localparam int DECK = 52;

    typedef struct {
        int         addr;
        logic [3:0] card;
        logic [3:0] points;
        logic       ace;
        logic       err;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       shuffled;
    logic       deal_req;
    logic       card_ack;
    logic [3:0] mem_data;
    logic [5:0] address;
    logic       mem_clk;
    logic       write_en;
    logic [3:0] card;
    logic [3:0] points;
    logic       is_ace;
    logic       card_err;
    logic       card_valid;
    logic       busy;
    logic       deck_empty;
    logic [5:0] cards_left;

    card_dealer dut (
        .clk         (clk),
        .i_Reset_n   (rst_n),
        .i_Shuffled  (shuffled),
        .i_DealReq   (deal_req),
        .i_CardAck   (card_ack),
        .i_MemData   (mem_data),
        .o_Address   (address),
        .o_MemClk    (mem_clk),
        .o_Write     (write_en),
        .o_Card      (card),
        .o_Points    (points),
        .o_IsAce     (is_ace),
        .o_CardErr   (card_err),
        .o_CardValid (card_valid),
        .o_Busy      (busy),
        .o_DeckEmpty (deck_empty),
        .o_CardsLeft (cards_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Deck memory model: read data appears on the rising memory clock.
    logic [3:0] mem [DECK];
    int         pulse_cnt = 0;
    int         last_pulse_addr = -1;

    always @(posedge mem_clk) begin
        mem_data        = mem[address];
        last_pulse_addr = int'(address);
        pulse_cnt       = pulse_cnt + 1;
    end

    // Scoreboard and model of deck position.
    exp_t sb_q[$];
    int   model_ptr;
    int   model_left;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic exp_t expect_card(input int addr);
        exp_t e;
        logic [3:0] r;
        r      = mem[addr];
        e.addr = addr;
        e.card = r;
        e.ace  = (r == 4'd1);
        e.err  = (r == 4'd0) || (r >= 4'd14);
        if (e.err)          e.points = 4'd0;
        else if (r >= 4'd10) e.points = 4'd10;
        else                e.points = r;
        return e;
    endfunction

    // Drive a request for one edge and return just after that edge (edge k).
    task automatic pulse_request();
        @(negedge clk);
        deal_req = 1'b1;
        @(posedge clk);
        #1;
        deal_req = 1'b0;
    endtask

    // Deal one card: optionally check cycle timing, hold without ack for
    // `hold` cycles, optionally present a request together with the ack.
    task automatic deal(input int hold, input bit timed, input bit req_with_ack);
        exp_t e;
        int   n;
        int   pc;
        bit   stable;
        logic [3:0] c0, p0;
        logic a0, r0;

        sb_q.push_back(expect_card(model_ptr));
        pulse_request();

        if (timed) begin
            @(posedge clk); #1;
            check("busy_k1", busy, 1);
            check("addr_k1", address, model_ptr);
            check("memclk_k1", mem_clk, 0);
            @(posedge clk); #1;
            check("memclk_k2", mem_clk, 1);
            @(posedge clk); #1;
            check("memclk_k3", mem_clk, 0);
            check("valid_k3", card_valid, 0);
            @(posedge clk); #1;
            check("valid_k4", card_valid, 1);
        end else begin
            n = 0;
            while (!card_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check("valid_timeout", card_valid, 1);
        end

        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("pulse_addr", last_pulse_addr, e.addr);
            check("card", card, e.card);
            check("points", points, e.points);
            check("is_ace", is_ace, e.ace);
            check("card_err", card_err, e.err);
            check("busy_present", busy, 0);
        end

        if (hold > 0) begin
            stable = 1'b1;
            c0 = card; p0 = points; a0 = is_ace; r0 = card_err;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (!card_valid || card !== c0 || points !== p0 ||
                    is_ace !== a0 || card_err !== r0) stable = 1'b0;
            end
            check("hold_stable", stable, 1);
        end

        pc = pulse_cnt;
        @(negedge clk);
        card_ack = 1'b1;
        deal_req = req_with_ack;
        @(posedge clk); #1;
        card_ack = 1'b0;
        deal_req = 1'b0;
        model_ptr++;
        model_left--;
        check("valid_after_ack", card_valid, 0);
        check("cards_left", cards_left, model_left);
        check("deck_empty", deck_empty, (model_left == 0));

        if (req_with_ack) begin
            repeat (4) @(posedge clk);
            #1;
            check("req_with_ack_busy", busy, 0);
            check("req_with_ack_pulses", pulse_cnt, pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;

        rst_n    = 1'b0;
        shuffled = 1'b0;
        deal_req = 1'b0;
        card_ack = 1'b0;
        mem_data = 4'd0;
        for (int i = 0; i < DECK; i++) mem[i] = 4'($urandom_range(0, 15));
        mem[0] = 4'd7;
        mem[1] = 4'd12;
        mem[2] = 4'd1;
        mem[3] = 4'd0;
        mem[4] = 4'd10;
        mem[5] = 4'd14;
        mem[6] = 4'd13;
        mem[7] = 4'd15;
        model_ptr  = 0;
        model_left = DECK;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_cards_left", cards_left, DECK);
        check("rst_memclk", mem_clk, 0);
        check("rst_valid", card_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_empty", deck_empty, 0);
        check("rst_address", address, 0);
        check("rst_write", write_en, 0);
        check("rst_card", card, 0);

        @(negedge clk);
        rst_n    = 1'b1;
        shuffled = 1'b1;

        // Cards 0..8: timing, stability, ace, face, error card, req+ack.
        deal(0, 1'b1, 1'b0);
        deal(20, 1'b0, 1'b0);
        deal(20, 1'b0, 1'b0);
        deal(0, 1'b0, 1'b0);
        deal(0, 1'b1, 1'b1);
        for (int i = 5; i < 9; i++) deal(0, 1'b0, 1'b0);

        // Card 10: drop i_Shuffled while the memory clock is high.
        pulse_request();
        repeat (2) @(posedge clk);
        #1;
        check("drop_memclk_high", mem_clk, 1);
        @(negedge clk);
        shuffled = 1'b0;
        @(posedge clk); #1;
        check("drop_memclk", mem_clk, 0);
        check("drop_cards_left", cards_left, DECK);
        check("drop_busy", busy, 0);
        check("drop_valid", card_valid, 0);
        @(negedge clk);
        shuffled   = 1'b1;
        model_ptr  = 0;
        model_left = DECK;
        deal(0, 1'b1, 1'b0);

        // Async reset while the memory clock is high.
        pulse_request();
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_memclk_high", mem_clk, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_memclk", mem_clk, 0);
        check("rst_mid_cards_left", cards_left, DECK);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_address", address, 0);
        check("rst_mid_card", card, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        model_ptr  = 0;
        model_left = DECK;

        // Whole deck.
        for (int i = 0; i < DECK; i++) deal(0, 1'b0, 1'b0);
        check("full_empty", deck_empty, 1);
        check("full_cards_left", cards_left, 0);

        // 53rd request: no memory access.
        pc = pulse_cnt;
        @(negedge clk);
        deal_req = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        deal_req = 1'b0;
        check("req53_pulses", pulse_cnt, pc);
        check("req53_busy", busy, 0);
        check("req53_valid", card_valid, 0);
        check("req53_empty", deck_empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
# card_dealer

Reads cards sequentially from the 52-entry deck memory after the shuffler has finished, and hands them one at a time to the game controller over a request/valid/acknowledge handshake. It is the read-side counterpart of the shuffler and drives the same memory port: address, single-cycle memory clock pulse, 4-bit data. Each card is decoded into its blackjack point value.

## Interface
- DECK_SIZE, 52, cards per deck; deck addresses are 0..DECK_SIZE-1.
- ADDR_W, 6, deck memory address width.
- DATA_W, 4, card rank width; ranks are 1=Ace … 13=King.

- clk  in  1  system clock; all logic is on the rising edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Shuffled  in  1  deck ready. While low, the block is held idle and the deck position is rewound.
- i_DealReq  in  1  deal request; sampled only in IDLE.
- i_CardAck  in  1  consumer has taken the card; sampled only in PRESENT.
- i_MemData  in  DATA_W  deck memory read data.
- o_Address  out  ADDR_W  deck memory address.
- o_MemClk  out  1  memory clock pulse.
- o_Write  out  1  memory write enable; constant 0.
- o_Card  out  DATA_W  rank of the presented card.
- o_Points  out  4  blackjack points: 1..10.
- o_IsAce  out  1  presented card is an Ace.
- o_CardErr  out  1  presented rank is 0, 14 or 15.
- o_CardValid  out  1  card outputs are valid.
- o_Busy  out  1  fetch in progress.
- o_DeckEmpty  out  1  all DECK_SIZE cards have been dealt.
- o_CardsLeft  out  ADDR_W  cards remaining, DECK_SIZE..0.

## Operation
- All outputs are registered. Reset values: every output is 0, except o_CardsLeft, which is DECK_SIZE. The internal pointer resets to 0.
- States and transitions:
  - IDLE: on i_Shuffled & i_DealReq & !o_DeckEmpty, go to SET_ADDR.
  - SET_ADDR: o_Address = pointer, o_Busy = 1.
  - MEM_CLK: o_MemClk = 1; address is held.
  - CAPTURE: o_MemClk = 0. i_MemData is registered into o_Card, and o_Points, o_IsAce and o_CardErr are decoded from it.
  - PRESENT: o_CardValid = 1, o_Busy = 0. On i_CardAck: increment pointer, decrement o_CardsLeft, clear o_CardValid, then go to EMPTY if pointer was DECK_SIZE-1, else IDLE.
  - EMPTY: o_DeckEmpty = 1; i_DealReq is ignored.
- Point decoding:
  - Ranks 1..10 give points equal to the rank.
  - Ranks 11..13 give 10 points.
  - Rank 1 also sets o_IsAce.
  - Ranks 0, 14 and 15 give o_Points = 0 and set o_CardErr. The card is still presented and consumed normally.
- i_Shuffled low in any state: next edge goes to IDLE. Pointer returns to 0, o_CardsLeft to DECK_SIZE, and all flags and o_MemClk clear. This is how a new shuffle restarts the deck.
- Async reset mid-fetch: immediate return to reset values. No partial memory pulse survives.
- The pointer never wraps. Reaching DECK_SIZE is the EMPTY state, never address 0.

## Timing
- i_DealReq sampled at edge k: SET_ADDR at k+1, o_MemClk high for exactly the cycle k+2..k+3, o_CardValid high from edge k+4.
- The address is stable from one cycle before the o_MemClk pulse until the pulse ends. i_MemData must be valid by edge k+3.
- o_Card, o_Points, o_IsAce and o_CardErr are stable for the whole time o_CardValid is high, including indefinitely without ack.
- i_CardAck sampled at edge m: o_CardValid falls at m. The next request is accepted at m+1 at the earliest.
- i_DealReq asserted together with i_CardAck in PRESENT is ignored; the requester re-asserts in IDLE.
- i_DealReq held high continuously deals back-to-back: 5 cycles per card plus ack latency.

## Structure
- Shared package deck_pkg holds:
  - constants DECK_SIZE, ADDR_W, DATA_W;
  - rank codes RANK_ACE=1, RANK_KING=13;
  - state encodings for card_dealer.
- Sub-module card_points: combinational, rank in; o_Points, o_IsAce and o_CardErr out. It is reused by the hand scorer.
- The top level holds the state machine, pointer/count registers and memory-port drivers.

## Test plan
- Reset asserted mid-MEM_CLK -> all outputs 0 and o_CardsLeft = 52 immediately; o_MemClk falls without waiting for a clock edge.
- mem[0]=7, request at edge k -> o_MemClk high k+2..k+3, o_Address=0, o_CardValid at k+4, o_Card=7, o_Points=7; ack -> o_CardsLeft=51.
- mem[1]=12, then mem[2]=1 -> first card: o_Points=10, o_IsAce=0. Second card: o_Points=1, o_IsAce=1. Each card is held stable for 20 cycles without ack.
- Deal all 52 with acks -> o_DeckEmpty=1 and o_CardsLeft=0 after the 52nd ack; a 53rd request produces no o_MemClk pulse.
- i_Shuffled dropped at MEM_CLK of card 10 -> IDLE next edge, o_MemClk=0, o_CardsLeft=52; after re-raise the next deal reads address 0.
- mem[3]=0 -> o_CardErr=1, o_Points=0; after ack, the next deal reads address 4.
